// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings for the master-port decoder slice.
// Provides HTRANS/HRESP codes, default-slave FSM states and slave counts.
package ahb_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic {
        HR_OKAY  = 1'b0,
        HR_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [1:0] {
        DS_OK   = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } def_state_e;

    localparam int NUM_SLV = 5;
    localparam int DEF_IDX = 5;

endpackage

// File: rtl/ahb_dec_sel_if.sv
// Master-port bus bundle between the AHB master side and the decoder.
// master: drives haddr/htrans/hready; slave: returns hsel/dsel/default resp.
interface ahb_dec_sel_if
    import ahb_pkg::*;
#(
    parameter int AW = 32
);
    logic [AW-1:0]      haddr;
    logic [1:0]         htrans;
    logic               hready;
    logic [NUM_SLV-1:0] hsel;
    logic [NUM_SLV:0]   dsel;
    logic               hreadyout_def;
    logic               hresp_def;

    modport master (
        output haddr, htrans, hready,
        input  hsel, dsel, hreadyout_def, hresp_def
    );

    modport slave (
        input  haddr, htrans, hready,
        output hsel, dsel, hreadyout_def, hresp_def
    );
endinterface

// File: rtl/ahb_default_slave.sv
// Default (error) slave: two-cycle ERROR for active unmapped transfers.
// In: clk, rst, hsel_def, htrans, hready. Out: hreadyout_def, hresp_def.
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       hsel_def,
    input  logic [1:0] htrans,
    input  logic       hready,
    output logic       hreadyout_def,
    output logic       hresp_def
);
    def_state_e state;
    def_state_e nxt;
    logic       err_req;

    // Only NONSEQ/SEQ need a response; IDLE/BUSY get a zero-wait OKAY.
    assign err_req = hready & hsel_def & htrans[1];

    always_ff @(posedge clk) begin
        if (rst) state <= DS_OK;
        else     state <= nxt;
    end

    // Outputs decode the registered state only.
    always_comb begin
        nxt           = DS_OK;
        hreadyout_def = 1'b1;
        hresp_def     = HR_OKAY;
        unique case (state)
            DS_OK: begin
                if (err_req) nxt = DS_ERR1;
            end
            DS_ERR1: begin
                hreadyout_def = 1'b0;
                hresp_def     = HR_ERROR;
                nxt           = DS_ERR2;
            end
            DS_ERR2: begin
                hresp_def = HR_ERROR;
                if (err_req) nxt = DS_ERR1;
            end
            default: nxt = DS_OK;
        endcase
    end
endmodule

// File: rtl/ahb_dec_sel.sv
// Address decoder and data-phase select for one AHB-Lite master port.
// In: clk, rst, bus.haddr/htrans/hready. Out: bus.hsel, dsel, default resp.
module ahb_dec_sel
    import ahb_pkg::*;
#(
    parameter int         AW     = 32,
    parameter logic [3:0] S0_REG = 4'h0,
    parameter logic [3:0] S1_REG = 4'h1,
    parameter logic [3:0] S2_REG = 4'h2,
    parameter logic [3:0] S3_REG = 4'h3,
    parameter logic [3:0] S4_REG = 4'h4
)(
    input  logic          clk,
    input  logic          rst,
    ahb_dec_sel_if.slave  bus
);
    logic [3:0]         tag;
    logic [NUM_SLV-1:0] hsel;
    logic               def_hit;
    logic [NUM_SLV:0]   dsel_q;

    assign tag = bus.haddr[AW-1 -: 4];

    // Priority chain keeps hsel one-hot even if region tags overlap.
    always_comb begin
        hsel = '0;
        if      (tag == S0_REG) hsel[0] = 1'b1;
        else if (tag == S1_REG) hsel[1] = 1'b1;
        else if (tag == S2_REG) hsel[2] = 1'b1;
        else if (tag == S3_REG) hsel[3] = 1'b1;
        else if (tag == S4_REG) hsel[4] = 1'b1;
    end

    assign def_hit = ~|hsel;

    // Reset selects the default slave so bus HREADY is high out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            dsel_q          <= '0;
            dsel_q[DEF_IDX] <= 1'b1;
        end else if (bus.hready) begin
            dsel_q <= {def_hit, hsel};
        end
    end

    ahb_default_slave u_def (
        .clk           (clk),
        .rst           (rst),
        .hsel_def      (def_hit),
        .htrans        (bus.htrans),
        .hready        (bus.hready),
        .hreadyout_def (bus.hreadyout_def),
        .hresp_def     (bus.hresp_def)
    );

    assign bus.hsel = hsel;
    assign bus.dsel = dsel_q;
endmodule
